// File: rtl/rotl_pkg.sv
// Shared types for the round-robin rotate scheduler: FSM states and width helpers.
package rotl_pkg;

  typedef enum logic {
    ROTL_IDLE = 1'b0,
    ROTL_LOCK = 1'b1
  } rotl_sched_state_t;

  function automatic int shift_w(input int d_width);
    return $clog2(d_width);
  endfunction

  function automatic int id_w(input int n_req);
    return $clog2(n_req);
  endfunction

endpackage

// File: rtl/rotl_core.sv
// Combinational log-stage left rotator: stage s rotates by 2**s when shift bit s is set.
module rotl_core import rotl_pkg::*; #(
  parameter int D_WIDTH = 64
) (
  input  logic [D_WIDTH-1:0]          data_i,
  input  logic [shift_w(D_WIDTH)-1:0] shift_i,
  output logic [D_WIDTH-1:0]          data_o
);

  localparam int SW = shift_w(D_WIDTH);

  logic [D_WIDTH-1:0] stage [SW+1];

  assign stage[0] = data_i;

  for (genvar s = 0; s < SW; s++) begin : g_stage
    localparam int AMT = 1 << s;
    assign stage[s+1] = shift_i[s] ? {stage[s][D_WIDTH-1-AMT:0], stage[s][D_WIDTH-1 -: AMT]}
                                   : stage[s];
  end

  assign data_o = stage[SW];

endmodule

// File: rtl/rotl_sched.sv
// Round-robin scheduler sharing one rotl_core among N_REQ requesters, registered response.
// Define ROTL_SCHED_BURST_EN to let an owner hold the grant for up to MAX_BURST beats.
module rotl_sched import rotl_pkg::*; #(
  parameter int D_WIDTH   = 64,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [N_REQ*D_WIDTH-1:0]            req_data_i,
  input  logic [N_REQ*$clog2(D_WIDTH)-1:0]    req_shift_i,
  input  logic [N_REQ-1:0]                    req_valid_i,
  output logic [N_REQ-1:0]                    req_ready_o,
  output logic [D_WIDTH-1:0]                  rsp_data_o,
  output logic [$clog2(N_REQ)-1:0]            rsp_id_o,
  output logic                                rsp_valid_o,
  input  logic                                rsp_ready_i
);

  localparam int SW = shift_w(D_WIDTH);
  localparam int IW = id_w(N_REQ);

  logic [IW-1:0]      last_q;
  logic [IW-1:0]      rr_idx;
  logic [IW-1:0]      grant_idx;
  logic               rr_found;
  logic               grant_valid;
  logic               out_free;
  logic               accept;
  logic [SW-1:0]      sel_shift;
  logic [D_WIDTH-1:0] sel_data;
  logic [D_WIDTH-1:0] rot_data;

  assign out_free = !rsp_valid_o || rsp_ready_i;
  assign accept   = grant_valid && out_free && !rst_i;

  // Search starts one past the last winner and wraps, so every requester waits at most N_REQ-1 beats.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!rr_found && req_valid_i[(int'(last_q) + k) % N_REQ]) begin
        rr_found = 1'b1;
        rr_idx   = IW'((int'(last_q) + k) % N_REQ);
      end
    end
  end

`ifdef ROTL_SCHED_BURST_EN
  localparam int CW = $clog2(MAX_BURST + 1);

  rotl_sched_state_t state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic              owner_hold;

  assign owner_hold  = (state_q == ROTL_LOCK) && req_valid_i[owner_q];
  assign grant_valid = owner_hold || rr_found;
  assign grant_idx   = owner_hold ? owner_q : rr_idx;

  // An owner dropping valid releases the lock in the same cycle; round robin then picks the beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    if (accept) begin
      if (owner_hold) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == CW'(MAX_BURST)) state_d = ROTL_IDLE;
      end else begin
        owner_d = rr_idx;
        cnt_d   = CW'(1);
        state_d = (MAX_BURST > 1) ? ROTL_LOCK : ROTL_IDLE;
      end
    end else if (out_free) begin
      state_d = ROTL_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ROTL_IDLE;
      cnt_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end
`else
  assign grant_valid = rr_found;
  assign grant_idx   = rr_idx;
`endif

  always_comb begin
    req_ready_o = '0;
    if (accept) req_ready_o[grant_idx] = 1'b1;
  end

  assign sel_data  = req_data_i[grant_idx*D_WIDTH +: D_WIDTH];
  assign sel_shift = req_shift_i[grant_idx*SW +: SW];

  rotl_core #(.D_WIDTH(D_WIDTH)) u_core (
    .data_i  (sel_data),
    .shift_i (sel_shift),
    .data_o  (rot_data)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q      <= IW'(N_REQ - 1);
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_id_o    <= '0;
    end else begin
      if (accept) last_q <= grant_idx;
      if (out_free) begin
        rsp_valid_o <= accept;
        if (accept) begin
          rsp_data_o <= rot_data;
          rsp_id_o   <= grant_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_rotl_sched.sv
// Directed bench for rotl_sched; burst scenarios are selected with ROTL_SCHED_BURST_EN.
module tb_rotl_sched;

  localparam int DW = 64;
  localparam int NR = 4;
  localparam int SW = 6;
  localparam int IW = 2;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [NR*DW-1:0] req_data_i;
  logic [NR*SW-1:0] req_shift_i;
  logic [NR-1:0]    req_valid_i;
  logic [NR-1:0]    req_ready_o;
  logic [DW-1:0]    rsp_data_o;
  logic [IW-1:0]    rsp_id_o;
  logic             rsp_valid_o;
  logic             rsp_ready_i;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [DW-1:0] A_IN  = 64'h0011_2233_4455_6677;  // shift 8
  localparam logic [DW-1:0] A_OUT = 64'h1122_3344_5566_7700;
  localparam logic [DW-1:0] B_IN  = 64'hAAAA_BBBB_CCCC_DDDD;  // shift 16
  localparam logic [DW-1:0] B_OUT = 64'hBBBB_CCCC_DDDD_AAAA;

  rotl_sched #(.D_WIDTH(DW), .N_REQ(NR), .MAX_BURST(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_data_i  (req_data_i),
    .req_shift_i (req_shift_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_id_o    (rsp_id_o),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic set_req(input int i, input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_data_i[i*DW +: DW]  = d;
    req_shift_i[i*SW +: SW] = s;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i       = 1'b1;
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Ready is checked mid-cycle before the edge, the response 1 ns after it.
  task automatic beat(input string name, input logic [IW-1:0] id, input logic [DW-1:0] data);
    #1;
    vectors++;
    if (req_ready_o !== 4'(1 << id)) begin
      miscompares++;
      $display("FAIL %s ready: got %b want %b", name, req_ready_o, 4'(1 << id));
    end
    @(posedge clk_i); #1;
    vectors++;
    if (rsp_valid_o !== 1'b1 || rsp_id_o !== id || rsp_data_o !== data) begin
      miscompares++;
      $display("FAIL %s rsp: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
               name, rsp_valid_o, rsp_id_o, rsp_data_o, id, data);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_i       = 1'b1;
    req_valid_i = '1;
    rsp_ready_i = 1'b1;
    req_data_i  = '0;
    req_shift_i = '0;
    @(negedge clk_i);
    vectors++;
    if (rsp_valid_o !== 1'b0 || rsp_data_o !== '0 || rsp_id_o !== '0) begin
      miscompares++;
      $display("FAIL reset_rsp: got v=%b id=%0d d=%h want all zero", rsp_valid_o, rsp_id_o, rsp_data_o);
    end
    vectors++;
    if (req_ready_o !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 0000", req_ready_o);
    end
  endtask

  task automatic test_single();
    req_valid_i = 4'b0100;
    set_req(2, 64'h8000_0000_0000_0001, 6'd1);
    rst_i = 1'b0;
    beat("single", 2'd2, 64'h0000_0000_0000_0003);
    req_valid_i = '0;
    @(posedge clk_i); #1;
    vectors++;
    if (rsp_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drain: got v=%b want 0", rsp_valid_o);
    end
  endtask

`ifndef ROTL_SCHED_BURST_EN
  task automatic test_round_robin();
    logic [DW-1:0] exp_d [NR];
    exp_d[0] = 64'hDEAD_BEEF_0123_4567;  // shift 0 leaves data unchanged
    exp_d[1] = 64'h1234_5678_9ABC_DEF0;
    exp_d[2] = 64'h8000_0000_0000_0000;
    exp_d[3] = 64'hFFFF_0000_0000_0000;
    do_reset();
    set_req(0, 64'hDEAD_BEEF_0123_4567, 6'd0);
    set_req(1, 64'h0123_4567_89AB_CDEF, 6'd4);
    set_req(2, 64'h0000_0000_0000_0001, 6'd63);
    set_req(3, 64'h0000_0000_FFFF_0000, 6'd32);
    req_valid_i = 4'b1111;
    for (int c = 0; c < 8; c++) beat("round_robin", IW'(c % NR), exp_d[c % NR]);
    req_valid_i = '0;
  endtask
`else
  task automatic test_burst();
    logic [IW-1:0] exp_id [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    do_reset();
    set_req(0, A_IN, 6'd8);
    set_req(1, B_IN, 6'd16);
    req_valid_i = 4'b0011;
    for (int c = 0; c < 10; c++) beat("burst", exp_id[c], exp_id[c] == 0 ? A_OUT : B_OUT);
    req_valid_i = '0;
  endtask

  task automatic test_owner_drop();
    do_reset();
    set_req(0, A_IN, 6'd8);
    set_req(1, B_IN, 6'd16);
    req_valid_i = 4'b0011;
    beat("drop_pre", 2'd0, A_OUT);
    beat("drop_pre", 2'd0, A_OUT);
    req_valid_i = 4'b0010;
    beat("drop_switch", 2'd1, B_OUT);
    beat("drop_next", 2'd1, B_OUT);
    req_valid_i = '0;
  endtask
`endif

  task automatic test_backpressure();
    logic [IW-1:0] exp_id [4];
    logic [DW-1:0] held;
`ifdef ROTL_SCHED_BURST_EN
    exp_id = '{0, 0, 0, 1};
`else
    exp_id = '{1, 0, 1, 0};
`endif
    do_reset();
    set_req(0, A_IN, 6'd8);
    set_req(1, B_IN, 6'd16);
    req_valid_i = 4'b0011;
    beat("bp_first", 2'd0, A_OUT);
    rsp_ready_i = 1'b0;
    held = rsp_data_o;
    for (int c = 0; c < 5; c++) begin
      #1;
      vectors++;
      if (req_ready_o !== 4'b0000) begin
        miscompares++;
        $display("FAIL bp_stall_ready: got %b want 0000", req_ready_o);
      end
      @(posedge clk_i); #1;
      vectors++;
      if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd0 || rsp_data_o !== A_OUT || rsp_data_o !== held) begin
        miscompares++;
        $display("FAIL bp_hold: got v=%b id=%0d d=%h want v=1 id=0 d=%h", rsp_valid_o, rsp_id_o, rsp_data_o, A_OUT);
      end
      @(negedge clk_i);
    end
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) beat("bp_resume", exp_id[c], exp_id[c] == 0 ? A_OUT : B_OUT);
    req_valid_i = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(1, B_IN, 6'd16);
    set_req(2, A_IN, 6'd8);
    req_valid_i = 4'b0110;
    beat("rmid_pre", 2'd1, B_OUT);
    rsp_ready_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    vectors++;
    if (rsp_valid_o !== 1'b0 || rsp_data_o !== '0 || rsp_id_o !== '0 || req_ready_o !== '0) begin
      miscompares++;
      $display("FAIL rmid_async: got v=%b id=%0d d=%h rdy=%b want all zero",
               rsp_valid_o, rsp_id_o, rsp_data_o, req_ready_o);
    end
    @(negedge clk_i);
    rst_i       = 1'b0;
    rsp_ready_i = 1'b1;
    set_req(0, A_IN, 6'd8);
    set_req(3, B_IN, 6'd16);
    req_valid_i = 4'b1111;
    beat("rmid_after", 2'd0, A_OUT);
    req_valid_i = '0;
  endtask

  initial begin
    test_reset();
    test_single();
`ifndef ROTL_SCHED_BURST_EN
    test_round_robin();
`else
    test_burst();
    test_owner_drop();
`endif
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rotl_sched.md
# rotl_sched

Round-robin scheduler sharing one left-rotate datapath among `N_REQ` requesters. Each requester presents a data word and a rotate amount with a valid/ready handshake. The scheduler grants one requester per cycle, rotates its word, and returns the result with the requester ID through a single registered response port that accepts backpressure. It sits between the hash/cipher round engines and the shared rotator, replacing per-engine rotators.

## Interface
- `D_WIDTH`, 64: data width; power of two, ≥ 2.
- `N_REQ`, 4: number of requesters, ≥ 2.
- `MAX_BURST`, 4: maximum consecutive beats one owner may hold the grant; ≥ 1, only used with the burst feature.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset; one clock; reset is asynchronous and active-high.
- `req_data_i`, in, `N_REQ`×`D_WIDTH`: word to rotate, per requester.
- `req_shift_i`, in, `N_REQ`×`$clog2(D_WIDTH)`: left-rotate amount, per requester.
- `req_valid_i`, in, `N_REQ`: request present, per requester.
- `req_ready_o`, out, `N_REQ`: request accepted this cycle; one-hot or zero.
- `rsp_data_o`, out, `D_WIDTH`: rotated word.
- `rsp_id_o`, out, `$clog2(N_REQ)`: index of the requester that produced `rsp_data_o`.
- `rsp_valid_o`, out, 1: response present.
- `rsp_ready_i`, in, 1: consumer accepts the response.

## Operation
- Result: `rsp_data_o` = `req_data_i[g]` rotated left by `req_shift_i[g]`, where `g` is the granted index. A shift of 0 passes the word unchanged. The MSB wraps into bit 0.
- Output slot: a single register stage. `out_free = !rsp_valid_o || rsp_ready_i`.
- Grant is combinational from the current valids, the pointer `last` and the FSM. `req_ready_o[g] = (grant == g) && out_free`. All `req_ready_o` bits are 0 while `rst_i` is high or no valid is present.
- Round robin: search starts at `last+1` and wraps modulo `N_REQ`. The first index with valid set wins. `last` updates to the winner on each accept.
- FSM (burst feature only), two states:
  - IDLE:
    - Arbitrate by round robin.
    - On accept: `owner` ← winner, `cnt` ← 1, go to LOCK when `MAX_BURST` > 1.
  - LOCK:
    - Grant `owner` if `req_valid_i[owner]` is high.
    - On accept: `cnt` increments. When `cnt` reaches `MAX_BURST`, return to IDLE.
    - If `req_valid_i[owner]` is low in a cycle where `out_free` is high, return to IDLE immediately in the same cycle. Round-robin arbitration applies to that cycle.
    - Backpressure (`out_free` low) holds both state and `cnt`.
- Valids are sampled only through the handshake. The block never drops or duplicates a beat.
- Response stays stable while `rsp_valid_o && !rsp_ready_i`.

## Timing
- Latency: accept at edge N; `rsp_valid_o`, `rsp_data_o` and `rsp_id_o` are valid after edge N.
- Throughput: one beat per cycle when `rsp_ready_i` is held high. Accept and response-drain can occur on the same edge.
- Reset values:
  - `rsp_valid_o` = 0, `rsp_data_o` = 0, `rsp_id_o` = 0.
  - `last` = `N_REQ-1`, so index 0 has first priority after reset.
  - FSM = IDLE, `cnt` = 0, `owner` = 0.
- Reset asserted mid-burst or with a response pending: the response is discarded, and all state returns to its reset value asynchronously.
- All requesters valid with round robin only: grants cycle 0,1,2,…,`N_REQ-1`,0,… with no gap cycles.

## Configuration
- `ROTL_SCHED_BURST_EN` defined:
  - The IDLE/LOCK FSM and `cnt` are compiled in.
  - An owner keeps the grant for up to `MAX_BURST` consecutive accepts.
- Not defined:
  - No FSM or counter; `MAX_BURST` is ignored.
  - Pure per-beat round robin.

## Structure
- Package `rotl_pkg`:
  - FSM state enum `rotl_sched_state_t` (`ROTL_IDLE`, `ROTL_LOCK`).
  - Typedef helpers for the shift width and ID width as functions of `D_WIDTH` and `N_REQ`.
- Sub-module `rotl_core`:
  - Purely combinational log-stage left rotator (`D_WIDTH`, data, shift in; rotated data out).
  - The scheduler instantiates exactly one.

## Test plan
- Reset release, requester 2 valid with data 0x8000_0000_0000_0001 and shift 1 -> `req_ready_o` = 0b0100; one edge later `rsp_data_o` = 0x0000_0000_0000_0003 and `rsp_id_o` = 2.
- All 4 valid, `rsp_ready_i` = 1, burst off -> IDs 0,1,2,3,0,… one per cycle; shift 0 returns data unchanged.
- Burst on, `MAX_BURST` = 4, requesters 0 and 1 valid continuously -> IDs 0,0,0,0,1,1,1,1,0,…
- Burst on, owner 0 drops valid after 2 beats with 1 still valid -> next accept is ID 1 in the same cycle, no bubble.
- `rsp_ready_i` = 0 for 5 cycles with response pending -> `req_ready_o` = 0, response held stable, `cnt` frozen; on release, beats resume in order with none lost.
- `rst_i` pulsed mid-burst with `rsp_valid_o` = 1 -> `rsp_valid_o` drops immediately; next grant goes to index 0.
